// File: rtl/seven_segment_ctrl_if.sv
// Bus between the game FSM and the seven-segment display controller.
//   sym_in     : packed digit symbols, digit d = sym_in[d*SYM_W +: SYM_W]
//   load       : single-cycle strobe, latches sym_in and reveal_en
//   reveal_en  : 1 = reveal digits left to right after the load
//   blink_mask : per-digit blink enable (live)
//   lamp_test  : force all segments on (live)
//   hex_out    : active-low {g,f,e,d,c,b,a} per digit, registered
//   busy       : reveal animation in progress
interface seven_segment_ctrl_if #(
  parameter int NUM_DIGITS = 4,
  parameter int SYM_W      = 4
);
  logic [NUM_DIGITS*SYM_W-1:0] sym_in;
  logic                        load;
  logic                        reveal_en;
  logic [NUM_DIGITS-1:0]       blink_mask;
  logic                        lamp_test;
  logic [NUM_DIGITS*7-1:0]     hex_out;
  logic                        busy;

  modport master (
    output sym_in, load, reveal_en, blink_mask, lamp_test,
    input  hex_out, busy
  );

  modport slave (
    input  sym_in, load, reveal_en, blink_mask, lamp_test,
    output hex_out, busy
  );
endinterface

// File: rtl/seven_segment_ctrl.sv
// Multi-digit seven-segment display controller.
// Latches digit symbols on load and drives registered active-low segment
// patterns, with per-digit blinking, an optional left-to-right reveal
// animation and a lamp test.
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : seven_segment_ctrl_if slave (symbols/strobes in, hex/busy out)
//
// state  | meaning
// IDLE   | all latched digits eligible for display, busy=0
// REVEAL | one more digit uncovered every REVEAL_TICKS cycles, busy=1
module seven_segment_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int SYM_W        = 4,
  parameter int BLINK_TICKS  = 25000000,
  parameter int REVEAL_TICKS = 12500000
) (
  input logic               clk,
  input logic               reset_n,
  seven_segment_ctrl_if.slave bus
);

  localparam int BW  = (BLINK_TICKS  > 1) ? $clog2(BLINK_TICKS)  : 1;
  localparam int RW  = (REVEAL_TICKS > 1) ? $clog2(REVEAL_TICKS) : 1;
  localparam int RVW = $clog2(NUM_DIGITS + 1);

  localparam logic [BW-1:0]  BLINK_LAST  = BW'(BLINK_TICKS - 1);
  localparam logic [RW-1:0]  REVEAL_LAST = RW'(REVEAL_TICKS - 1);
  localparam logic [RVW-1:0] ALL_DIGITS  = RVW'(NUM_DIGITS);
  localparam logic [RVW-1:0] LAST_DIGIT  = RVW'(NUM_DIGITS - 1);

  typedef enum logic {IDLE, REVEAL} state_t;

  state_t                      state_q;
  logic [NUM_DIGITS*SYM_W-1:0] sym_q;
  logic [RVW-1:0]              revealed_q;
  logic                        busy_q;
  logic                        phase_q;
  logic [BW-1:0]               bcnt_q;
  logic [RW-1:0]               rcnt_q;
  logic [NUM_DIGITS*7-1:0]     hex_q;
  logic [NUM_DIGITS*7-1:0]     hex_d;

  function automatic logic [6:0] glyph(input logic [SYM_W-1:0] s);
    logic [3:0] v;
    v = 4'(s);
    case (v)
      4'd1:    glyph = 7'b1111001;
      4'd2:    glyph = 7'b0100100;
      4'd3:    glyph = 7'b0110000;
      4'd4:    glyph = 7'b0011001;
      4'd5:    glyph = 7'b0010010;
      4'd6:    glyph = 7'b0000010;
      4'd7:    glyph = 7'b1111000;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0010000;
      4'd10:   glyph = 7'b0001000;
      4'd11:   glyph = 7'b0000011;
      4'd12:   glyph = 7'b1000110;
      4'd13:   glyph = 7'b0100001;
      4'd14:   glyph = 7'b0000110;
      4'd15:   glyph = 7'b0001110;
      default: glyph = 7'b1111111;
    endcase
  endfunction

  // Lamp test beats reveal masking, which beats blinking.
  always_comb begin
    hex_d = '1;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (bus.lamp_test) begin
        hex_d[d*7 +: 7] = 7'b0000000;
      end else if (d >= int'(revealed_q)) begin
        hex_d[d*7 +: 7] = 7'b1111111;
      end else if (bus.blink_mask[d] && phase_q) begin
        hex_d[d*7 +: 7] = 7'b1111111;
      end else begin
        hex_d[d*7 +: 7] = glyph(sym_q[d*SYM_W +: SYM_W]);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      sym_q      <= '0;
      revealed_q <= ALL_DIGITS;
      busy_q     <= 1'b0;
      phase_q    <= 1'b0;
      bcnt_q     <= '0;
      rcnt_q     <= '0;
      hex_q      <= '1;
    end else begin
      hex_q <= hex_d;

      // A load realigns the blink so new symbols start visible.
      if (bus.load) begin
        bcnt_q  <= '0;
        phase_q <= 1'b0;
      end else if (bcnt_q == BLINK_LAST) begin
        bcnt_q  <= '0;
        phase_q <= ~phase_q;
      end else begin
        bcnt_q <= bcnt_q + 1'b1;
      end

      // Load has priority over the animation and restarts it.
      if (bus.load) begin
        sym_q  <= bus.sym_in;
        rcnt_q <= '0;
        if (bus.reveal_en) begin
          revealed_q <= '0;
          busy_q     <= 1'b1;
          state_q    <= REVEAL;
        end else begin
          revealed_q <= ALL_DIGITS;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
      end else begin
        case (state_q)
          IDLE: ;
          REVEAL: begin
            if (rcnt_q == REVEAL_LAST) begin
              rcnt_q     <= '0;
              revealed_q <= revealed_q + 1'b1;
              if (revealed_q == LAST_DIGIT) begin
                busy_q  <= 1'b0;
                state_q <= IDLE;
              end
            end else begin
              rcnt_q <= rcnt_q + 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.hex_out = hex_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_seven_segment_ctrl.sv
// Self-checking bench for seven_segment_ctrl. The reference model works from
// the number of clock edges elapsed since the last load rather than from
// counters: digits revealed = min(N, k/REVEAL_TICKS), blink phase =
// (k/BLINK_TICKS) mod 2.
module tb_seven_segment_ctrl;

  localparam int N  = 4;
  localparam int RT = 4;
  localparam int BT = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  seven_segment_ctrl_if #(.NUM_DIGITS(N), .SYM_W(4)) bus ();
  seven_segment_ctrl_if #(.NUM_DIGITS(2), .SYM_W(3)) bus3 ();

  seven_segment_ctrl #(.NUM_DIGITS(N), .SYM_W(4), .BLINK_TICKS(BT), .REVEAL_TICKS(RT)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus));

  seven_segment_ctrl #(.NUM_DIGITS(2), .SYM_W(3), .BLINK_TICKS(1), .REVEAL_TICKS(1)) dut3 (
    .clk(clk), .reset_n(reset_n), .bus(bus3));

  logic [6:0] GLYPH [16] = '{
    7'b1111111, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  int errors = 0;
  int checks = 0;

  // Model state: symbols and mode of the last load, edges since that load.
  logic [15:0] sym_m = '0;
  logic        rev_mode = 1'b0;
  int          k = 0;

  function automatic logic [27:0] model_hex(input int kp, input logic lamp, input logic [3:0] mask);
    logic [27:0] r;
    int rev;
    int ph;
    rev = rev_mode ? ((kp / RT > N) ? N : kp / RT) : N;
    ph  = (kp / BT) % 2;
    r   = '1;
    for (int d = 0; d < N; d++) begin
      if (lamp)                            r[d*7 +: 7] = 7'b0000000;
      else if (d >= rev)                   r[d*7 +: 7] = 7'b1111111;
      else if (mask[d] && ph == 1)         r[d*7 +: 7] = 7'b1111111;
      else                                 r[d*7 +: 7] = GLYPH[sym_m[d*4 +: 4]];
    end
    return r;
  endfunction

  task automatic step();
    logic        lp;
    logic [3:0]  mk;
    int          kp;
    logic [27:0] eh;
    logic        eb;
    lp = bus.lamp_test;
    mk = bus.blink_mask;
    kp = k;
    @(posedge clk);
    #1;
    k++;
    eh = model_hex(kp, lp, mk);
    eb = rev_mode && (k < N * RT);
    checks++;
    assert (bus.hex_out === eh)
      else begin errors++; $error("FAIL hex k=%0d observed=%b expected=%b", k, bus.hex_out, eh); end
    checks++;
    assert (bus.busy === eb)
      else begin errors++; $error("FAIL busy k=%0d observed=%b expected=%b", k, bus.busy, eb); end
  endtask

  task automatic do_load(input logic [15:0] s, input logic rev);
    bus.sym_in    = s;
    bus.reveal_en = rev;
    bus.load      = 1'b1;
    @(posedge clk);
    #1;
    bus.load = 1'b0;
    sym_m    = s;
    rev_mode = rev;
    k        = 0;
  endtask

  initial begin
    bus.sym_in = '0; bus.load = 1'b0; bus.reveal_en = 1'b0;
    bus.blink_mask = '0; bus.lamp_test = 1'b0;
    bus3.sym_in = '0; bus3.load = 1'b0; bus3.reveal_en = 1'b0;
    bus3.blink_mask = '0; bus3.lamp_test = 1'b0;

    // Reset state
    #12;
    checks++;
    assert (bus.hex_out === 28'hFFFFFFF)
      else begin errors++; $error("FAIL reset_hex observed=%h expected=%h", bus.hex_out, 28'hFFFFFFF); end
    checks++;
    assert (bus.busy === 1'b0)
      else begin errors++; $error("FAIL reset_busy observed=%b expected=0", bus.busy); end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) step();

    // Plain load, glyphs one edge later
    do_load(16'h6521, 1'b0);
    step();
    checks++;
    assert (bus.hex_out === {7'b0000010, 7'b0010010, 7'b0100100, 7'b1111001})
      else begin errors++; $error("FAIL load_6521 observed=%b expected=%b", bus.hex_out,
                                  {7'b0000010, 7'b0010010, 7'b0100100, 7'b1111001}); end

    // Reveal with a lamp-test burst in the middle
    do_load(16'h4321, 1'b1);
    for (int i = 0; i < 20; i++) begin
      bus.lamp_test = (i >= 6 && i < 9);
      step();
    end
    bus.lamp_test = 1'b0;

    // Blink on digit 1, then a reload realigns the phase
    bus.blink_mask = 4'b0010;
    do_load(16'h8765, 1'b0);
    repeat (14) step();
    do_load(16'h8765, 1'b0);
    repeat (5) step();
    bus.blink_mask = 4'b0000;

    // Symbols 0, 10, 15, 11
    do_load(16'hBFA0, 1'b0);
    step();
    checks++;
    assert (bus.hex_out === {7'b0000011, 7'b0001110, 7'b0001000, 7'b1111111})
      else begin errors++; $error("FAIL sym_edge observed=%b expected=%b", bus.hex_out,
                                  {7'b0000011, 7'b0001110, 7'b0001000, 7'b1111111}); end

    // Randomized loads, masks, lamp test and reload-during-reveal
    for (int t = 0; t < 30; t++) begin
      bus.blink_mask = 4'($urandom);
      do_load(16'($urandom), 1'($urandom));
      for (int j = 0; j < int'($urandom_range(1, 24)); j++) begin
        bus.lamp_test  = ($urandom % 6 == 0);
        if ($urandom % 8 == 0) bus.blink_mask = 4'($urandom);
        step();
      end
      bus.lamp_test = 1'b0;
    end
    bus.blink_mask = 4'b0000;

    // 3-bit symbols: digit0 = 7, digit1 = 3
    bus3.sym_in = 6'b011_111;
    bus3.load   = 1'b1;
    @(posedge clk);
    #1;
    bus3.load = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    assert (bus3.hex_out === {7'b0110000, 7'b1111000})
      else begin errors++; $error("FAIL sym3 observed=%b expected=%b", bus3.hex_out, {7'b0110000, 7'b1111000}); end

    // Asynchronous reset in the middle of a reveal
    do_load(16'h1234, 1'b1);
    repeat (6) step();
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    assert (bus.hex_out === 28'hFFFFFFF)
      else begin errors++; $error("FAIL async_rst_hex observed=%h expected=%h", bus.hex_out, 28'hFFFFFFF); end
    checks++;
    assert (bus.busy === 1'b0)
      else begin errors++; $error("FAIL async_rst_busy observed=%b expected=0", bus.busy); end
    @(negedge clk);
    reset_n  = 1'b1;
    sym_m    = '0;
    rev_mode = 1'b0;
    k        = 0;
    repeat (6) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
